fifo_mem_ctrl: RTL and testbench
================================

Name: fifo_mem_ctrl

Overview:
FIFO controller that sits directly upstream of the single-port-pair synchronous RAM (`mem`) and drives its write and read ports. It turns a push/pop stream interface into RAM addresses and enables, and tracks occupancy (full, empty, almost-full). It also re-times the RAM's registered read data into a valid-qualified output. The RAM itself stays a separate instance beside this block.

Parameters:
- mem_width, 16: data width; must equal the RAM instance's data width.
- mem_depth, 1024: number of entries; power of two; must equal the RAM depth.
- add_size, 10: address width, log2(mem_depth).
- af_level, 1020: count at or above which almost_full asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush; pointers and count go to 0, sticky flags are cleared.
- push  in  1  write request.
- push_data  in  mem_width  data to write.
- pop  in  1  read request.
- rd_data  out  mem_width  pop data, valid when rd_valid=1.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  count == mem_depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_level.
- count  out  add_size+1  current occupancy.
- overflow  out  1  sticky; set on a push while full.
- underflow  out  1  sticky; set on a pop while empty.
- blk_slect  out  1  to RAM; wr_en | rd_en.
- wr_en  out  1  to RAM; push accepted.
- addr_wr  out  add_size  to RAM; wr_ptr[add_size-1:0].
- din  out  mem_width  to RAM; equals push_data.
- rd_en  out  1  to RAM; pop accepted.
- addr_rd  out  add_size  to RAM; rd_ptr[add_size-1:0].
- mem_dout  in  mem_width  from RAM dout.

Behaviour:
- Reset (rst=0, async): wr_ptr, rd_ptr, count, overflow, underflow and rd_valid are all 0. Consequently empty=1, full=0, almost_full=0.
- Pointers are add_size+1 bits wide. The MSB is the wrap bit.
  - full when the address bits are equal and the MSBs differ.
  - empty when the pointers are fully equal.
- count is a register. On each edge: +1 on an accepted push only, -1 on an accepted pop only, unchanged when both or neither are accepted.
- Acceptance, evaluated combinationally from the current registered state:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Push and pop in the same cycle are both accepted when neither condition blocks them.
  - On full, a push is rejected even if a pop is accepted in the same cycle. No bypass.
  - On empty, a pop is rejected even if a push is accepted in the same cycle.
- RAM drive is combinational:
  - wr_en = push_acc, rd_en = pop_acc, blk_slect = push_acc | pop_acc.
  - addr_wr and addr_rd come from the current pointers; din = push_data.
- Pointers increment on the edge after acceptance. Wrap from mem_depth-1 to 0 happens naturally in the low bits, and the MSB toggles.
- Read latency is 1 cycle:
  - rd_valid is registered as pop_acc.
  - rd_data = mem_dout (the RAM registers it on the same edge).
  - With back-to-back pops, rd_valid stays 1 every cycle.
- rd_data is undefined when rd_valid=0. The bench must not check it then.
- overflow sets on push & full; underflow sets on pop & empty. Both hold until clr or rst.
- clr (sync) has priority over push and pop in the same cycle: nothing is accepted and rd_valid goes to 0 next cycle.
- Reset mid-operation: all state drops immediately. RAM contents are not cleared, but they are unreachable because the pointers are reset.
- The RAM's own reset input is not driven by this block. The top level ties it inactive.

Decomposition:
- No package is needed. The parameters are passed down from the top level.
- A sub-module, fifo_ptr (pointer register with wrap bit and increment enable), is natural and is instantiated twice. Everything else stays in fifo_mem_ctrl.
- The top-level test wrapper instantiates fifo_mem_ctrl plus mem.

Test Plan:
- Reset, then push 3 words (0x0001, 0x0002, 0x0003), then pop 3 back to back. Expect rd_valid on 3 consecutive cycles, starting one cycle after the first pop, with data 0x0001, 0x0002, 0x0003 in order. count goes 3 to 0 and empty returns to 1.
- Fill with 1024 pushes. Expect full=1, count=1024, almost_full set from count 1020. A 1025th push sets overflow=1 and count stays 1024.
- Pop on empty after reset. Expect underflow=1, rd_en=0, rd_valid stays 0, count stays 0.
- With count=5, push and pop together for 10 cycles. Expect count to remain 5 and read data to follow FIFO order.
- Push/pop 2500 words at steady state with count of about 8. Expect correct data across pointer wrap, and full never asserted.
- Assert clr with count=7 while push=1 and pop=1. Expect count=0, empty=1, overflow and underflow cleared, no RAM enables, and rd_valid=0 the next cycle.
- Assert rst low asynchronously mid-stream with count=50. Expect all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared defaults for the FIFO controller slice.
// Parameter values used when the block is instantiated without overrides.
package fifo_mem_ctrl_pkg;

  localparam int MEM_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF = 1024;
  localparam int ADD_SIZE_DEF  = 10;
  localparam int AF_LEVEL_DEF  = 1020;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register with wrap bit.
// Low bits address the RAM; the MSB toggles on every wrap.
module fifo_ptr #(
  parameter int add_size = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [add_size:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Push/pop FIFO controller driving an external synchronous RAM.
// Tracks occupancy and re-times RAM read data into a valid-qualified stream.
module fifo_mem_ctrl
  import fifo_mem_ctrl_pkg::*;
#(
  parameter int mem_width = MEM_WIDTH_DEF,
  parameter int mem_depth = MEM_DEPTH_DEF,
  parameter int add_size  = ADD_SIZE_DEF,
  parameter int af_level  = AF_LEVEL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic [mem_width-1:0] push_data,
  input  logic                 pop,
  output logic [mem_width-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [add_size:0]    count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 blk_slect,
  output logic                 wr_en,
  output logic [add_size-1:0]  addr_wr,
  output logic [mem_width-1:0] din,
  output logic                 rd_en,
  output logic [add_size-1:0]  addr_rd,
  input  logic [mem_width-1:0] mem_dout
);

  localparam logic [add_size:0] AF_C =
    (add_size+1)'(af_level);

  if (mem_depth != (1 << add_size)) begin : g_bad_depth
    $error("mem_depth must equal 2**add_size");
  end

  logic [add_size:0] wr_ptr;
  logic [add_size:0] rd_ptr;
  logic              push_acc;
  logic              pop_acc;

  fifo_ptr #(
    .add_size(add_size)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(push_acc),
    .ptr(wr_ptr)
  );

  fifo_ptr #(
    .add_size(add_size)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(pop_acc),
    .ptr(rd_ptr)
  );

  // Same RAM index with opposite wrap bits means one full lap ahead.
  assign full =
    (wr_ptr[add_size-1:0] == rd_ptr[add_size-1:0]) &
    (wr_ptr[add_size] ^ rd_ptr[add_size]);
  assign empty = (wr_ptr == rd_ptr);

  assign push_acc = push & ~full & ~clr;
  assign pop_acc  = pop & ~empty & ~clr;

  assign wr_en     = push_acc;
  assign rd_en     = pop_acc;
  assign blk_slect = push_acc | pop_acc;
  assign addr_wr   = wr_ptr[add_size-1:0];
  assign addr_rd   = rd_ptr[add_size-1:0];
  assign din       = push_data;

  assign rd_data     = mem_dout;
  assign almost_full = (count >= AF_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (push & full) begin
        overflow <= 1'b1;
      end
      if (pop & empty) begin
        underflow <= 1'b1;
      end
      rd_valid <= pop_acc;
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomized scoreboard bench for fifo_mem_ctrl with a behavioural RAM.
// A queue model predicts occupancy, flags and the popped data stream.
module tb_fifo_mem_ctrl;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int A  = 10;
  localparam int AF = 1020;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         push;
  logic [W-1:0] push_data;
  logic         pop;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic [A:0]   count;
  logic         overflow;
  logic         underflow;
  logic         blk_slect;
  logic         wr_en;
  logic [A-1:0] addr_wr;
  logic [W-1:0] din;
  logic         rd_en;
  logic [A-1:0] addr_rd;
  logic [W-1:0] mem_dout;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(
    .mem_width(W),
    .mem_depth(D),
    .add_size(A),
    .af_level(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .blk_slect(blk_slect),
    .wr_en(wr_en),
    .addr_wr(addr_wr),
    .din(din),
    .rd_en(rd_en),
    .addr_rd(addr_rd),
    .mem_dout(mem_dout)
  );

  logic [W-1:0] ram [D];

  always @(posedge clk) begin
    if (wr_en) ram[addr_wr] <= din;
    if (rd_en) mem_dout <= ram[addr_rd];
  end

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] expq[$];
  int  mw, mr, npop;
  bit  movf, mund, mrv;
  bit  pa, qa;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    mw = 0;
    mr = 0;
    movf = 0;
    mund = 0;
    mrv = 0;
  endtask

  task automatic check_regs();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("underflow", 32'(underflow), 32'(mund));
    chk("rd_valid", 32'(rd_valid), 32'(mrv));
  endtask

  task automatic step(input bit p, input logic [W-1:0] d,
                      input bit o, input bit c);
    @(negedge clk);
    check_regs();
    push = p;
    push_data = d;
    pop = o;
    clr = c;
    #1;
    pa = p && !c && (mq.size() < D);
    qa = o && !c && (mq.size() > 0);
    chk("wr_en", 32'(wr_en), 32'(pa));
    chk("rd_en", 32'(rd_en), 32'(qa));
    chk("blk_slect", 32'(blk_slect), 32'(pa | qa));
    chk("din", 32'(din), 32'(d));
    chk("addr_wr", 32'(addr_wr), 32'(mw));
    chk("addr_rd", 32'(addr_rd), 32'(mr));
    @(posedge clk);
    if (c) begin
      mq.delete();
      mw = 0;
      mr = 0;
      movf = 0;
      mund = 0;
      mrv = 0;
    end else begin
      if (p && mq.size() == D) movf = 1;
      if (o && mq.size() == 0) mund = 1;
      if (qa) begin
        expq.push_back(mq.pop_front());
        mr = (mr + 1) % D;
        npop++;
      end
      if (pa) begin
        mq.push_back(d);
        mw = (mw + 1) % D;
      end
      mrv = qa;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    push_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h expected none at %0t",
                 rd_data, $time);
      end else begin
        e = expq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit p, o;
    npop = 0;
    do_reset();
    step(0, '0, 0, 0);

    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);

    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    step(1, 16'h0003, 0, 0);
    repeat (3) step(0, '0, 1, 0);
    repeat (2) step(0, '0, 0, 0);

    for (int i = 0; i < D; i++)
      step(1, W'($urandom), 0, 0);
    step(1, 16'hdead, 0, 0);
    step(1, 16'hbeef, 1, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < D; i++)
      step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    for (int i = 0; i < 5; i++)
      step(1, W'($urandom), 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, W'($urandom), 1, 0);
    step(0, '0, 0, 0);

    npop = 0;
    for (int k = 0; k < 20000 && npop < 2500; k++) begin
      p = (mq.size() < 8) ? 1'b1 : 1'($urandom);
      o = (mq.size() > 8) ? 1'b1 : 1'($urandom);
      step(p, W'($urandom), o, 0);
    end
    repeat (2) step(0, '0, 0, 0);
    chk("steady_pops", 32'(npop >= 2500), 32'd1);

    step(0, '0, 0, 1);
    step(0, '0, 1, 0);
    for (int i = 0; i < 7; i++)
      step(1, W'($urandom), 0, 0);
    step(1, 16'h1234, 1, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);

    for (int i = 0; i < 50; i++)
      step(1, W'($urandom), 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, W'($urandom), 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_af", 32'(almost_full), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_und", 32'(underflow), 32'd0);
    chk("arst_rv", 32'(rd_valid), 32'd0);
    chk("arst_addr_wr", 32'(addr_wr), 32'd0);
    chk("arst_addr_rd", 32'(addr_rd), 32'd0);
    model_reset();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    step(1, 16'h00aa, 0, 0);
    step(0, '0, 1, 0);
    repeat (3) step(0, '0, 0, 0);
    chk("expq_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
